// File: rtl/bsg_tag_tx_pkg.sv
// Shared definitions for the bsg_tag serial packet transmitter: FSM state
// encoding and frame-width helpers used by the RTL and the bench.
package bsg_tag_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        HDR,
        PAY,
        GAP
    } tx_state_e;

    // Header: start bit, length field, data_not_reset flag, node id.
    function automatic int hdr_len(input int lg_width, input int id_width);
        return 2 + lg_width + id_width;
    endfunction

    function automatic int frame_len(input int lg_width, input int id_width,
                                     input int payload_len);
        return hdr_len(lg_width, id_width) + payload_len;
    endfunction

endpackage

// File: rtl/bsg_tag_tx_piso.sv
// Loadable LSB-first shift register with a remaining-bit down-counter;
// done_o is high once every loaded bit has been shifted out.
module bsg_tag_tx_piso #(
    parameter int width_p       = 15,
    parameter int count_width_p = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     load_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [count_width_p-1:0] count_i,
    input  logic                     shift_i,
    output logic                     bit_o,
    output logic                     done_o
);

    logic [width_p-1:0]       shift_r;
    logic [count_width_p-1:0] count_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shift_r <= '0;
            count_r <= '0;
        end else if (load_i) begin
            shift_r <= data_i;
            count_r <= count_i;
        end else if (shift_i && (count_r != '0)) begin
            shift_r <= shift_r >> 1;
            count_r <= count_r - 1'b1;
        end
    end

    assign bit_o  = shift_r[0];
    assign done_o = (count_r == '0);

endmodule

// File: rtl/bsg_tag_packet_tx.sv
// Serializes bsg_tag commands (data/client-reset packets or a master-reset
// stream) onto the registered TAG_EN / TAG_DATA pins, one bit per clock.
module bsg_tag_packet_tx
    import bsg_tag_tx_pkg::*;
#(
    parameter int  els_p               = 16,
    parameter int  lg_width_p          = 4,
    parameter int  max_payload_width_p = 15,
    parameter int  reset_len_p         = 32,
    localparam int id_width_lp         = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           v_i,
    output logic                           ready_o,
    input  logic                           reset_cmd_i,
    input  logic [id_width_lp-1:0]         node_id_i,
    input  logic                           data_not_reset_i,
    input  logic [lg_width_p-1:0]          len_i,
    input  logic [max_payload_width_p-1:0] payload_i,
    output logic                           tag_en_o,
    output logic                           tag_data_o,
    output logic                           err_o
);

    localparam int hdr_len_lp          = hdr_len(lg_width_p, id_width_lp);
    localparam int hdr_rest_lp         = hdr_len_lp - 1;
    localparam int piso_width_lp       = (hdr_rest_lp > max_payload_width_p)
                                         ? hdr_rest_lp : max_payload_width_p;
    localparam int piso_count_width_lp = $clog2(piso_width_lp + 1);
    localparam int rst_count_width_lp  = $clog2(reset_len_p + 1);
    localparam logic [lg_width_p-1:0] max_len_lp = lg_width_p'(max_payload_width_p);

    tx_state_e                      state_r, state_n;
    logic [rst_count_width_lp-1:0]  rst_cnt_r, rst_cnt_n;
    logic [lg_width_p-1:0]          len_r;
    logic [max_payload_width_p-1:0] payload_r;
    logic                           tag_en_r, tag_en_n;
    logic                           tag_data_r, tag_data_n;
    logic                           err_r, err_n;
    logic                           capture;

    logic                           piso_load, piso_shift, piso_bit, piso_done;
    logic [piso_width_lp-1:0]       piso_data;
    logic [piso_count_width_lp-1:0] piso_count;

    bsg_tag_tx_piso #(
        .width_p      (piso_width_lp),
        .count_width_p(piso_count_width_lp)
    ) piso (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .load_i (piso_load),
        .data_i (piso_data),
        .count_i(piso_count),
        .shift_i(piso_shift),
        .bit_o  (piso_bit),
        .done_o (piso_done)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= IDLE;
            rst_cnt_r  <= '0;
            len_r      <= '0;
            payload_r  <= '0;
            tag_en_r   <= 1'b0;
            tag_data_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_n;
            rst_cnt_r  <= rst_cnt_n;
            tag_en_r   <= tag_en_n;
            tag_data_r <= tag_data_n;
            err_r      <= err_n;
            if (capture) begin
                len_r     <= len_i;
                payload_r <= payload_i;
            end
        end
    end

    // The pin flops are loaded with the bit for the *next* cycle, so the
    // start bit is set on the accept edge and appears the cycle after.
    always_comb begin
        state_n    = state_r;
        rst_cnt_n  = rst_cnt_r;
        tag_en_n   = 1'b0;
        tag_data_n = 1'b0;
        err_n      = 1'b0;
        capture    = 1'b0;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        piso_data  = '0;
        piso_count = '0;
        unique case (state_r)
            IDLE: begin
                if (v_i) begin
                    if (reset_cmd_i) begin
                        state_n    = RST;
                        tag_en_n   = 1'b1;
                        tag_data_n = 1'b1;
                        rst_cnt_n  = rst_count_width_lp'(reset_len_p - 1);
                    end else if (len_i <= max_len_lp) begin
                        state_n    = HDR;
                        tag_en_n   = 1'b1;
                        tag_data_n = 1'b1;
                        capture    = 1'b1;
                        piso_load  = 1'b1;
                        piso_data  = piso_width_lp'({node_id_i, data_not_reset_i, len_i});
                        piso_count = piso_count_width_lp'(hdr_rest_lp);
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RST: begin
                tag_en_n = 1'b1;
                if (rst_cnt_r != '0) begin
                    tag_data_n = 1'b1;
                    rst_cnt_n  = rst_cnt_r - 1'b1;
                end else begin
                    state_n = GAP;
                end
            end
            HDR: begin
                tag_en_n = 1'b1;
                if (!piso_done) begin
                    tag_data_n = piso_bit;
                    piso_shift = 1'b1;
                end else if (len_r == '0) begin
                    state_n = GAP;
                end else begin
                    // First payload bit goes straight to the pin; the rest is reloaded.
                    state_n    = PAY;
                    tag_data_n = payload_r[0];
                    piso_load  = 1'b1;
                    piso_data  = piso_width_lp'(payload_r >> 1);
                    piso_count = piso_count_width_lp'(len_r - 1'b1);
                end
            end
            PAY: begin
                tag_en_n = 1'b1;
                if (!piso_done) begin
                    tag_data_n = piso_bit;
                    piso_shift = 1'b1;
                end else begin
                    state_n = GAP;
                end
            end
            GAP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign ready_o    = (state_r == IDLE) && !reset_i;
    assign tag_en_o   = tag_en_r;
    assign tag_data_o = tag_data_r;
    assign err_o      = err_r;

endmodule
